// File: rtl/mem_stage_sramlike_pkg.sv
// Shared types and constants for the MEM stage: bus layouts, exception code,
// load-op encodings and FSM states.
package mem_stage_sramlike_pkg;

  localparam int unsigned ES_TO_MS_BUS_WD = 148;
  localparam int unsigned MS_TO_WS_BUS_WD = 110;

  // Exception codes seen by this stage
  localparam logic [4:0] NO_EX   = 5'h1f;
  localparam logic [4:0] EX_ADEL = 5'h04;

  // Load operation encodings; 3'd7 is reserved and behaves as LW
  typedef enum logic [2:0] {
    LOAD_LW  = 3'd0,
    LOAD_LB  = 3'd1,
    LOAD_LBU = 3'd2,
    LOAD_LH  = 3'd3,
    LOAD_LHU = 3'd4,
    LOAD_LWL = 3'd5,
    LOAD_LWR = 3'd6
  } load_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_PASS = 2'd3
  } ms_state_e;

  typedef struct packed {
    logic        pc_error;
    logic [31:0] badvaddr;
    logic [4:0]  ex_code;
    logic        eret;
    logic        bd;
    logic [2:0]  load_op;
    logic        mem_rd;
    logic [1:0]  addr_low;
    logic [31:0] rt_value;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_bus_t;

  typedef struct packed {
    logic        pc_error;
    logic [31:0] badvaddr;
    logic [4:0]  ex_code;
    logic        eret;
    logic        bd;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_to_ws_bus_t;

  // Reset image of the latched EX bus: all zero except "no exception"
  function automatic es_to_ms_bus_t es_bus_reset();
    es_to_ms_bus_t b;
    b         = '0;
    b.ex_code = NO_EX;
    return b;
  endfunction

endpackage

// File: rtl/mem_stage_sramlike_load_align.sv
// Combinational load data extraction: byte/half select with sign/zero
// extension and LWL/LWR merge with the old rt value.
module mem_stage_sramlike_load_align
  import mem_stage_sramlike_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  addr_low,
  input  logic [31:0] w,
  input  logic [31:0] rt,
  output logic [31:0] result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and half from the returned word
  always_comb begin
    byte_sel = w[7:0];
    case (addr_low)
      2'd0:    byte_sel = w[7:0];
      2'd1:    byte_sel = w[15:8];
      2'd2:    byte_sel = w[23:16];
      default: byte_sel = w[31:24];
    endcase
    half_sel = addr_low[1] ? w[31:16] : w[15:0];
  end

  // Format the result according to the load operation
  always_comb begin
    result_c = w;
    case (load_op)
      LOAD_LB:  result_c = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LBU: result_c = {24'd0, byte_sel};
      LOAD_LH:  result_c = {{16{half_sel[15]}}, half_sel};
      LOAD_LHU: result_c = {16'd0, half_sel};
      LOAD_LWL: begin
        case (addr_low)
          2'd0:    result_c = {w[7:0],  rt[23:0]};
          2'd1:    result_c = {w[15:0], rt[15:0]};
          2'd2:    result_c = {w[23:0], rt[7:0]};
          default: result_c = w;
        endcase
      end
      LOAD_LWR: begin
        case (addr_low)
          2'd0:    result_c = w;
          2'd1:    result_c = {rt[31:24], w[31:8]};
          2'd2:    result_c = {rt[31:16], w[31:16]};
          default: result_c = {rt[31:8],  w[31:24]};
        endcase
      end
      default:  result_c = w;
    endcase
  end

endmodule

// File: rtl/mem_stage_sramlike.sv
// MEM pipeline stage: latches the EX bus, waits for data-SRAM read data on
// loads, aligns load data and drives the MS->WS bus plus decode hazard info.
// Responses belonging to flushed loads are counted and dropped.
// Build option: MEM_FORWARD_EN drives MEM_dest_data with the stage result.
module mem_stage_sramlike
  import mem_stage_sramlike_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       flush,
  output logic [4:0]                 MEM_dest,
  output logic [31:0]                MEM_dest_data,
  output logic                       MEM_load_pending
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  ms_state_e      state_q, state_d;
  es_to_ms_bus_t  bus_q, bus_d;
  es_to_ms_bus_t  es_bus;
  ms_to_ws_bus_t  out_bus;
  logic           data_captured_q, data_captured_d;
  logic [31:0]    data_buf_q, data_buf_d;
  logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d, cnt_after_drop;

  logic        ms_valid;
  logic        has_ex;
  logic        capture_c;
  logic        drop_c;
  logic        orphan_c;
  logic        data_captured_c;
  logic        ms_ready_go;
  logic        latch_c;
  logic [31:0] load_word;
  logic [31:0] aligned;
  logic [31:0] final_result;

  assign es_bus = es_to_ms_bus_t'(es_to_ms_bus);

  // Handshake and load-status terms
  assign ms_valid        = (state_q != ST_IDLE);
  assign has_ex          = (bus_q.ex_code != NO_EX);
  assign capture_c       = (state_q == ST_WAIT) & data_sram_data_ok & (discard_cnt_q == '0);
  assign drop_c          = data_sram_data_ok & (discard_cnt_q != '0);
  assign orphan_c        = flush & (state_q == ST_WAIT) & ~capture_c;
  assign data_captured_c = data_captured_q | capture_c;
  assign ms_ready_go     = ~bus_q.mem_rd | data_captured_c | has_ex;
  assign ms_allowin      = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid  = ms_valid & ms_ready_go & ~flush;
  assign latch_c         = es_to_ms_valid & ms_allowin & ~flush;
  assign MEM_load_pending = ms_valid & bus_q.mem_rd & ~data_captured_c;
  assign MEM_dest        = ms_valid ? bus_q.dest : 5'd0;

  // Use the buffered word once captured, otherwise the live response
  assign load_word = data_captured_q ? data_buf_q : data_sram_rdata;

  mem_stage_sramlike_load_align u_load_align (
    .load_op  (bus_q.load_op),
    .addr_low (bus_q.addr_low),
    .w        (load_word),
    .rt       (bus_q.rt_value),
    .result_c (aligned)
  );

  assign final_result = bus_q.mem_rd ? aligned : bus_q.alu_result;

  // Assemble the outgoing bus; faulting instructions never write the GPR
  always_comb begin
    out_bus              = '0;
    out_bus.pc_error     = bus_q.pc_error;
    out_bus.badvaddr     = bus_q.badvaddr;
    out_bus.ex_code      = bus_q.ex_code;
    out_bus.eret         = bus_q.eret;
    out_bus.bd           = bus_q.bd;
    out_bus.gr_we        = bus_q.gr_we & ~has_ex;
    out_bus.dest         = bus_q.dest;
    out_bus.final_result = final_result;
    out_bus.pc           = bus_q.pc;
  end

  assign ms_to_ws_bus = MS_TO_WS_BUS_WD'(out_bus);

`ifdef MEM_FORWARD_EN
  assign MEM_dest_data = (ms_valid & ms_ready_go) ? final_result : 32'd0;
`else
  assign MEM_dest_data = 32'd0;
`endif

  // Next state, bus latch and load-data capture
  always_comb begin
    state_d         = state_q;
    bus_d           = bus_q;
    data_captured_d = data_captured_q;
    data_buf_d      = data_buf_q;
    if (capture_c) begin
      data_buf_d = data_sram_rdata;
    end
    if (flush) begin
      state_d         = ST_IDLE;
      data_captured_d = 1'b0;
    end else if (latch_c) begin
      bus_d           = es_bus;
      data_captured_d = 1'b0;
      // Faulting loads issue no request, so they go straight to PASS
      state_d = (es_bus.mem_rd && (es_bus.ex_code == NO_EX)) ? ST_WAIT : ST_PASS;
    end else if (ms_to_ws_valid & ws_allowin) begin
      state_d         = ST_IDLE;
      data_captured_d = 1'b0;
    end else if (capture_c) begin
      state_d         = ST_HOLD;
      data_captured_d = 1'b1;
    end else if (state_q == ST_PASS) begin
      state_d = ST_HOLD;
    end
  end

  // Count responses still owed to flushed loads, saturating at the limit
  always_comb begin
    cnt_after_drop = drop_c ? (discard_cnt_q - CNT_W'(1)) : discard_cnt_q;
    discard_cnt_d  = cnt_after_drop;
    if (orphan_c && (cnt_after_drop < CNT_W'(MAX_OUTSTANDING))) begin
      discard_cnt_d = cnt_after_drop + CNT_W'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      bus_q           <= es_bus_reset();
      data_captured_q <= 1'b0;
      data_buf_q      <= '0;
      discard_cnt_q   <= '0;
    end else begin
      state_q         <= state_d;
      bus_q           <= bus_d;
      data_captured_q <= data_captured_d;
      data_buf_q      <= data_buf_d;
      discard_cnt_q   <= discard_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sramlike.sv
// Self-checking bench for mem_stage_sramlike: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mem_stage_sramlike;
  import mem_stage_sramlike_pkg::*;

  localparam int MAX_OUT = 2;

  logic         clk = 1'b0;
  logic         resetn;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [147:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [109:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         flush;
  logic [4:0]   MEM_dest;
  logic [31:0]  MEM_dest_data;
  logic         MEM_load_pending;

  mem_stage_sramlike #(.MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .flush             (flush),
    .MEM_dest          (MEM_dest),
    .MEM_dest_data     (MEM_dest_data),
    .MEM_load_pending  (MEM_load_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_error;
    logic [31:0] badv;
    logic [4:0]  ex;
    logic        eret;
    logic        bd;
    logic [2:0]  op;
    logic        mem_rd;
    logic [1:0]  a;
    logic [31:0] rt;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
  } inst_t;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the stage: the instruction held, whether its data arrived,
  // and how many responses are still owed to killed loads
  logic        m_have;
  inst_t       m_inst;
  logic        m_got;
  logic [31:0] m_word;
  int          m_junk;
  int          sram_out;

  logic         obs_valid, obs_allowin, obs_pending;
  logic [109:0] obs_bus;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [147:0] pack_es(input inst_t i);
    return {i.pc_error, i.badv, i.ex, i.eret, i.bd, i.op, i.mem_rd, i.a,
            i.rt, i.gr_we, i.dest, i.alu, i.pc};
  endfunction

  function automatic inst_t mk_inst(input logic mem_rd, input logic [2:0] op,
                                    input logic [1:0] a, input logic [31:0] rt,
                                    input logic [4:0] dest);
    inst_t i;
    i.pc_error = 1'b0; i.badv = 32'd0; i.ex = NO_EX; i.eret = 1'b0; i.bd = 1'b0;
    i.op = op; i.mem_rd = mem_rd; i.a = a; i.rt = rt; i.gr_we = 1'b1;
    i.dest = dest; i.alu = 32'h0a1b2c3d; i.pc = 32'hbfc00100;
    return i;
  endfunction

  function automatic inst_t rand_inst();
    inst_t i;
    i.pc_error = ($urandom_range(0, 15) == 0);
    i.badv     = $urandom;
    i.ex       = ($urandom_range(0, 7) == 0) ? EX_ADEL : NO_EX;
    i.eret     = ($urandom_range(0, 15) == 0);
    i.bd       = 1'($urandom);
    i.op       = 3'($urandom);
    i.mem_rd   = 1'($urandom);
    i.a        = 2'($urandom);
    i.rt       = $urandom;
    i.gr_we    = 1'($urandom);
    i.dest     = 5'($urandom);
    i.alu      = $urandom;
    i.pc       = $urandom;
    return i;
  endfunction

  // Reference load formatting by shifting and masking the word
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] w, input logic [31:0] rt);
    int unsigned k;
    logic [31:0] b, h;
    k = 32'(a);
    b = (w >> (8 * k)) & 32'h0000_00ff;
    h = (w >> (16 * (k / 2))) & 32'h0000_ffff;
    case (op)
      3'd1:    return b[7]  ? (b | 32'hffff_ff00) : b;
      3'd2:    return b;
      3'd3:    return h[15] ? (h | 32'hffff_0000) : h;
      3'd4:    return h;
      3'd5:    return (w << (8 * (3 - k))) | (rt & (32'hffff_ffff >> (8 * (k + 1))));
      3'd6:    return (w >> (8 * k)) | (rt & ~(32'hffff_ffff >> (8 * k)));
      default: return w;
    endcase
  endfunction

  // One clock cycle: drive, compare at mid-cycle, advance the model
  task automatic step(input logic es_v, input inst_t ni, input logic wsa,
                      input logic fl, input logic dok, input logic [31:0] rd);
    logic fault, waiting, cap_now, ready, e_allowin, e_valid, e_pending, accept;
    logic [4:0]   e_dest;
    logic [31:0]  e_res, e_fwd;
    logic [109:0] e_bus;
    int junk_n;
    es_to_ms_valid    = es_v;
    es_to_ms_bus      = pack_es(ni);
    ws_allowin        = wsa;
    flush             = fl;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    #4;
    fault     = m_have && (m_inst.ex != NO_EX);
    waiting   = m_have && m_inst.mem_rd && !fault && !m_got;
    cap_now   = waiting && dok && (m_junk == 0);
    ready     = !m_inst.mem_rd || m_got || cap_now || fault;
    e_allowin = !m_have || (ready && wsa);
    e_valid   = m_have && ready && !fl;
    e_pending = m_have && m_inst.mem_rd && !(m_got || cap_now);
    e_dest    = m_have ? m_inst.dest : 5'd0;
    e_res     = m_inst.mem_rd ? ref_load(m_inst.op, m_inst.a, m_got ? m_word : rd, m_inst.rt)
                              : m_inst.alu;
`ifdef MEM_FORWARD_EN
    e_fwd = (m_have && ready) ? e_res : 32'd0;
`else
    e_fwd = 32'd0;
`endif
    e_bus = {m_inst.pc_error, m_inst.badv, m_inst.ex, m_inst.eret, m_inst.bd,
             m_inst.gr_we && (m_inst.ex == NO_EX), m_inst.dest, e_res, m_inst.pc};
    obs_valid   = ms_to_ws_valid;
    obs_allowin = ms_allowin;
    obs_pending = MEM_load_pending;
    obs_bus     = ms_to_ws_bus;
    check("ms_allowin", 128'(ms_allowin), 128'(e_allowin));
    check("ms_to_ws_valid", 128'(ms_to_ws_valid), 128'(e_valid));
    check("MEM_load_pending", 128'(MEM_load_pending), 128'(e_pending));
    check("MEM_dest", 128'(MEM_dest), 128'(e_dest));
    check("MEM_dest_data", 128'(MEM_dest_data), 128'(e_fwd));
    if (e_valid) check("ms_to_ws_bus", 128'(ms_to_ws_bus), 128'(e_bus));
    junk_n = m_junk;
    if (dok && m_junk > 0) junk_n--;
    if (fl && waiting && !cap_now && junk_n < MAX_OUT) junk_n++;
    accept = es_v && e_allowin && !fl;
    if (dok && sram_out > 0) sram_out--;
    if (accept && ni.mem_rd && (ni.ex == NO_EX)) sram_out++;
    if (fl) begin
      m_have = 1'b0; m_got = 1'b0;
    end else if (accept) begin
      m_have = 1'b1; m_inst = ni; m_got = 1'b0;
    end else if (e_valid && wsa) begin
      m_have = 1'b0; m_got = 1'b0;
    end else if (cap_now) begin
      m_got = 1'b1; m_word = rd;
    end
    m_junk = junk_n;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_have = 1'b0; m_got = 1'b0; m_word = 32'd0; m_junk = 0; sram_out = 0;
    m_inst = mk_inst(1'b0, 3'd0, 2'd0, 32'd0, 5'd0);
  endtask

  inst_t nop, ld;

  initial begin
    nop = mk_inst(1'b0, 3'd0, 2'd0, 32'd0, 5'd0);
    model_reset();
    resetn = 1'b0;
    es_to_ms_valid = 1'b0; es_to_ms_bus = '0; ws_allowin = 1'b1; flush = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'd0;
    #12;
    check("rst_valid", 128'(ms_to_ws_valid), 128'(0));
    check("rst_allowin", 128'(ms_allowin), 128'(1));
    check("rst_dest", 128'(MEM_dest), 128'(0));
    check("rst_pending", 128'(MEM_load_pending), 128'(0));
    @(posedge clk); #1;
    resetn = 1'b1;

    // LB sign extension, data in first MEM cycle
    step(1'b1, mk_inst(1'b1, 3'd1, 2'd3, 32'd0, 5'd4), 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, nop, 1'b1, 1'b0, 1'b1, 32'h80ff_1234);
    check("lb_valid", 128'(obs_valid), 128'(1));
    check("lb_result", 128'(obs_bus[63:32]), 128'(32'hffff_ff80));
    step(1'b0, nop, 1'b1, 1'b0, 1'b0, 32'd0);

    // LWL merge, data three cycles late
    step(1'b1, mk_inst(1'b1, 3'd5, 2'd1, 32'haabb_ccdd, 5'd7), 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, nop, 1'b1, 1'b0, 1'b0, 32'd0);
      check("lwl_pending", 128'(obs_pending), 128'(1));
    end
    step(1'b0, nop, 1'b1, 1'b0, 1'b1, 32'h1122_3344);
    check("lwl_result", 128'(obs_bus[63:32]), 128'(32'h3344_ccdd));

    // Flush while waiting: first response belongs to the killed load
    step(1'b1, mk_inst(1'b1, 3'd0, 2'd0, 32'd0, 5'd3), 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, nop, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, nop, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, mk_inst(1'b1, 3'd0, 2'd0, 32'd0, 5'd9), 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, nop, 1'b1, 1'b0, 1'b1, 32'hdead_0000);
    check("flush_drop_valid", 128'(obs_valid), 128'(0));
    step(1'b0, nop, 1'b1, 1'b0, 1'b1, 32'h0000_beef);
    check("flush_second_result", 128'(obs_bus[63:32]), 128'(32'h0000_beef));

    // WB backpressure on an ALU op
    ld = mk_inst(1'b0, 3'd0, 2'd0, 32'd0, 5'd12);
    ld.alu = 32'h55aa_0011;
    step(1'b1, ld, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, nop, 1'b0, 1'b0, 1'b0, 32'd0);
      check("bp_allowin", 128'(obs_allowin), 128'(0));
      check("bp_result", 128'(obs_bus[63:32]), 128'(32'h55aa_0011));
    end
    step(1'b0, nop, 1'b1, 1'b0, 1'b0, 32'd0);
    check("bp_release_valid", 128'(obs_valid), 128'(1));
    step(1'b0, nop, 1'b1, 1'b0, 1'b0, 32'd0);
    check("bp_after_valid", 128'(obs_valid), 128'(0));

    // Faulting load passes without a response
    ld = mk_inst(1'b1, 3'd0, 2'd1, 32'd0, 5'd5);
    ld.ex = EX_ADEL; ld.badv = 32'h1234_5677;
    step(1'b1, ld, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, nop, 1'b1, 1'b0, 1'b0, 32'd0);
    check("fault_valid", 128'(obs_valid), 128'(1));
    check("fault_gr_we", 128'(obs_bus[69]), 128'(0));
    check("fault_badv", 128'(obs_bus[108:77]), 128'(32'h1234_5677));

    // Async reset while a load waits and a killed response is owed
    step(1'b1, mk_inst(1'b1, 3'd0, 2'd0, 32'd0, 5'd2), 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, nop, 1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, mk_inst(1'b1, 3'd0, 2'd0, 32'd0, 5'd6), 1'b1, 1'b0, 1'b0, 32'd0);
    es_to_ms_valid = 1'b0; flush = 1'b0; data_sram_data_ok = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_valid", 128'(ms_to_ws_valid), 128'(0));
    check("arst_dest", 128'(MEM_dest), 128'(0));
    check("arst_pending", 128'(MEM_load_pending), 128'(0));
    check("arst_allowin", 128'(ms_allowin), 128'(1));
    @(posedge clk); #1;
    resetn = 1'b1;
    model_reset();
    step(1'b1, mk_inst(1'b1, 3'd0, 2'd0, 32'd0, 5'd8), 1'b1, 1'b0, 1'b0, 32'd0);
    step(1'b0, nop, 1'b1, 1'b0, 1'b1, 32'hcafe_f00d);
    check("arst_cnt_cleared", 128'(obs_bus[63:32]), 128'(32'hcafe_f00d));
    step(1'b0, nop, 1'b1, 1'b0, 1'b0, 32'd0);

    // Randomized traffic with a responder that only answers issued loads
    for (int n = 0; n < 3000; n++) begin
      logic dok, fl;
      dok = (sram_out > 0) && ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 19) == 0) && (sram_out <= MAX_OUT);
      step(1'($urandom_range(0, 1)), rand_inst(), ($urandom_range(0, 3) != 0),
           fl, dok, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
